clk_tick_gen: RTL and testbench

- Single-clock timebase block fed directly by the bench/system clock generator (`clk`).
- Produces a programmable periodic one-cycle tick, a half-rate square-wave enable and a free-running cycle timestamp.
- Timestamp is readable through a four-phase snapshot handshake.
- Downstream logic (timers, bus monitors, frequency checkers) uses it instead of measuring `$time`.

---
 rtl/clk_tick_gen.sv | 100 ++++++++++
 tb/tb_clk_tick_gen.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/clk_tick_gen.sv
// clk_tick_gen: programmable periodic tick, half-rate enable and cycle timestamp with snapshot handshake
module clk_tick_gen #(
    parameter int CNT_WIDTH   = 16,
    parameter int STAMP_WIDTH = 64,
    parameter int DIV_DEFAULT = 100
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   enable,
    input  logic                   div_valid,
    output logic                   div_ready,
    input  logic [CNT_WIDTH-1:0]   div_value,
    output logic                   tick,
    output logic                   half,
    output logic [STAMP_WIDTH-1:0] stamp,
    input  logic                   snap_req,
    output logic                   snap_ack,
    output logic [STAMP_WIDTH-1:0] snap_value
);
    localparam logic [CNT_WIDTH-1:0]   ONE       = CNT_WIDTH'(1);
    localparam logic [STAMP_WIDTH-1:0] STAMP_ONE = STAMP_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0]   DIV_INIT  = (DIV_DEFAULT == 0) ? ONE : CNT_WIDTH'(DIV_DEFAULT);

    typedef enum logic {T_IDLE, T_RUN} tick_state_t;
    typedef enum logic {S_WAIT, S_ACK} snap_state_t;

    tick_state_t            r_tstate, w_tstate_nxt;
    snap_state_t            r_sstate, w_sstate_nxt;
    logic [CNT_WIDTH-1:0]   r_cnt, r_div, r_pend;
    logic [CNT_WIDTH-1:0]   w_cnt_nxt, w_div_nxt, w_pend_nxt;
    logic                   r_pend_v, r_tick, r_half;
    logic                   w_pend_v_nxt, w_tick_nxt, w_apply, w_capture;
    logic [STAMP_WIDTH-1:0] r_stamp, r_snap;

    // Tick next state: count enabled cycles down, reload at period end or when disabled, and
    // swap in a pending divisor only on a tick edge or an edge spent idle
    always_comb begin
        w_tstate_nxt = enable ? T_RUN : T_IDLE;
        w_tick_nxt   = enable && (r_cnt == '0);
        w_apply      = r_pend_v && (w_tick_nxt || (r_tstate == T_IDLE && !enable));
        w_div_nxt    = w_apply ? r_pend : r_div;
        w_cnt_nxt    = (w_tick_nxt || !enable) ? w_div_nxt - ONE : r_cnt - ONE;
        w_pend_v_nxt = r_pend_v ? !w_apply : div_valid;
        w_pend_nxt   = (!r_pend_v && div_valid) ? ((div_value == '0) ? ONE : div_value) : r_pend;
    end

    // Tick state, down-counter, divisor registers and tick/half outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_tstate <= T_IDLE;
            r_cnt    <= DIV_INIT - ONE;
            r_div    <= DIV_INIT;
            r_pend   <= '0;
            r_pend_v <= 1'b0;
            r_tick   <= 1'b0;
            r_half   <= 1'b0;
        end else begin
            r_tstate <= w_tstate_nxt;
            r_cnt    <= w_cnt_nxt;
            r_div    <= w_div_nxt;
            r_pend   <= w_pend_nxt;
            r_pend_v <= w_pend_v_nxt;
            r_tick   <= w_tick_nxt;
            r_half   <= r_half ^ w_tick_nxt;
        end
    end

    // Free-running cycle timestamp, wraps silently
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_stamp <= '0;
        end else begin
            r_stamp <= r_stamp + STAMP_ONE;
        end
    end

    // Snapshot next state: ACK simply follows the sampled request; capture only on WAIT->ACK
    always_comb begin
        w_sstate_nxt = snap_req ? S_ACK : S_WAIT;
        w_capture    = (r_sstate == S_WAIT) && snap_req;
    end

    // Snapshot state and captured timestamp (pre-increment value of the capturing edge)
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sstate <= S_WAIT;
            r_snap   <= '0;
        end else begin
            r_sstate <= w_sstate_nxt;
            if (w_capture) r_snap <= r_stamp;
        end
    end

    assign div_ready  = !r_pend_v;
    assign tick       = r_tick;
    assign half       = r_half;
    assign stamp      = r_stamp;
    assign snap_ack   = (r_sstate == S_ACK);
    assign snap_value = r_snap;
endmodule

// File: tb/tb_clk_tick_gen.sv
// tb_clk_tick_gen: directed and randomized checks of clk_tick_gen against a period-counting model
module tb_clk_tick_gen;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        enable = 1'b0;
    logic        div_valid = 1'b0;
    logic [15:0] div_value = '0;
    logic        snap_req = 1'b0;

    logic        div_ready, tick, half, snap_ack;
    logic [63:0] stamp, snap_value;
    logic        div_ready8, tick8, half8, snap_ack8;
    logic [7:0]  stamp8, snap_value8;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    clk_tick_gen #(.CNT_WIDTH(16), .STAMP_WIDTH(64), .DIV_DEFAULT(4)) u_dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .div_valid(div_valid),
        .div_ready(div_ready), .div_value(div_value), .tick(tick), .half(half),
        .stamp(stamp), .snap_req(snap_req), .snap_ack(snap_ack), .snap_value(snap_value)
    );

    clk_tick_gen #(.CNT_WIDTH(16), .STAMP_WIDTH(8), .DIV_DEFAULT(4)) u_dut8 (
        .clk(clk), .reset_n(reset_n), .enable(enable), .div_valid(div_valid),
        .div_ready(div_ready8), .div_value(div_value), .tick(tick8), .half(half8),
        .stamp(stamp8), .snap_req(snap_req), .snap_ack(snap_ack8), .snap_value(snap_value8)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: count enabled edges within the current period; a period ends when that count
    // reaches the active divisor. A pending divisor is adopted at a period end or on an edge
    // where enable was low both before and at that edge.
    int          m_div = 4, m_pend = 0, m_k = 0;
    bit          m_pend_v = 0, m_run = 0;
    bit          e_tick = 0, e_half = 0, e_ack = 0;
    logic [63:0] e_stamp = '0, e_snap = '0;

    initial forever begin
        @(posedge clk or negedge reset_n);
        if (!reset_n) begin
            m_div = 4; m_pend = 0; m_k = 0; m_pend_v = 0; m_run = 0;
            e_tick = 0; e_half = 0; e_ack = 0; e_stamp = '0; e_snap = '0;
        end else begin
            bit apply, take;
            if (!e_ack && snap_req) begin
                e_snap = e_stamp;
                e_ack  = 1;
            end else if (e_ack && !snap_req) begin
                e_ack = 0;
            end
            e_stamp = e_stamp + 64'd1;
            apply = 0;
            if (enable) begin
                m_k++;
                e_tick = (m_k == m_div);
                if (e_tick) begin
                    m_k    = 0;
                    e_half = !e_half;
                    apply  = m_pend_v;
                end
            end else begin
                e_tick = 0;
                m_k    = 0;
                apply  = m_pend_v && !m_run;
            end
            take = !m_pend_v && div_valid;
            if (apply) begin
                m_div    = m_pend;
                m_pend_v = 0;
            end
            if (take) begin
                m_pend   = (div_value == 0) ? 1 : int'(div_value);
                m_pend_v = 1;
            end
            m_run = enable;
        end
    end

    // Every-cycle comparison of both instances against the model
    initial forever begin
        @(negedge clk);
        chk("tick",        64'(tick),        64'(e_tick));
        chk("half",        64'(half),        64'(e_half));
        chk("stamp",       stamp,            e_stamp);
        chk("div_ready",   64'(div_ready),   64'(!m_pend_v));
        chk("snap_ack",    64'(snap_ack),    64'(e_ack));
        chk("snap_value",  snap_value,       e_snap);
        chk("tick8",       64'(tick8),       64'(e_tick));
        chk("half8",       64'(half8),       64'(e_half));
        chk("stamp8",      64'(stamp8),      64'(e_stamp[7:0]));
        chk("div_ready8",  64'(div_ready8),  64'(!m_pend_v));
        chk("snap_ack8",   64'(snap_ack8),   64'(e_ack));
        chk("snap_value8", 64'(snap_value8), 64'(e_snap[7:0]));
    end

    initial begin
        bit found;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("rst_stamp", stamp, 64'd0);
        chk("rst_ready", 64'(div_ready), 64'd1);
        chk("rst_tick", 64'(tick), 64'd0);
        chk("rst_half", 64'(half), 64'd0);
        chk("rst_ack", 64'(snap_ack), 64'd0);
        enable = 1'b1;
        // Divisor 4: ticks after enabled edges 4, 8, 12
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            chk("lit_tick4", 64'(tick), 64'(i % 4 == 0));
            chk("lit_half4", 64'(half), 64'((i / 4) % 2));
            chk("lit_model_tick4", 64'(e_tick), 64'(i % 4 == 0));
            chk("lit_stamp", stamp, 64'(i));
        end
        // Load divisor 3 mid-period: period in flight still ends at edge 16
        @(negedge clk);
        div_valid = 1'b1;
        div_value = 16'd3;
        @(negedge clk);
        div_valid = 1'b0;
        chk("lit_ready_low", 64'(div_ready), 64'd0);
        for (int j = 15; j <= 22; j++) begin
            @(negedge clk);
            chk("lit_tick_div3", 64'(tick), 64'(j == 16 || j == 19 || j == 22));
            chk("lit_ready_div3", 64'(div_ready), 64'(j >= 16));
        end
        chk("lit_half_22", 64'(half), 64'd0);
        // Divisor 0 behaves as 1: tick every enabled cycle, half toggles each cycle
        enable    = 1'b0;
        div_valid = 1'b1;
        div_value = 16'd0;
        @(negedge clk);
        div_valid = 1'b0;
        @(negedge clk);
        chk("lit_ready_div1", 64'(div_ready), 64'd1);
        enable = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            chk("lit_tick_div1", 64'(tick), 64'd1);
            chk("lit_half_div1", 64'(half), 64'(k % 2));
        end
        // Snapshot at stamp 37 (now at edge 28)
        repeat (9) @(negedge clk);
        chk("lit_stamp37", stamp, 64'd37);
        snap_req = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("lit_snap_ack", 64'(snap_ack), 64'd1);
            chk("lit_snap_37", snap_value, 64'd37);
        end
        snap_req = 1'b0;
        @(negedge clk);
        chk("lit_snap_drop", 64'(snap_ack), 64'd0);
        chk("lit_snap_hold", snap_value, 64'd37);
        // 8-bit stamp wrap and snapshot at 255
        found = 0;
        for (int k = 0; k < 300 && !found; k++) begin
            @(negedge clk);
            found = (stamp8 == 8'd255);
        end
        chk("wait_stamp8_255", 64'(found), 64'd1);
        snap_req = 1'b1;
        @(negedge clk);
        chk("lit_stamp8_wrap", 64'(stamp8), 64'd0);
        chk("lit_snap8_255", 64'(snap_value8), 64'd255);
        snap_req = 1'b0;
        @(negedge clk);
        // Async reset mid-snapshot with a divisor pending
        snap_req  = 1'b1;
        div_valid = 1'b1;
        div_value = 16'd7;
        @(negedge clk);
        div_valid = 1'b0;
        chk("lit_pre_rst_ack", 64'(snap_ack), 64'd1);
        chk("lit_pre_rst_ready", 64'(div_ready), 64'd0);
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_tick", 64'(tick), 64'd0);
        chk("arst_half", 64'(half), 64'd0);
        chk("arst_stamp", stamp, 64'd0);
        chk("arst_ack", 64'(snap_ack), 64'd0);
        chk("arst_snap", snap_value, 64'd0);
        chk("arst_ready", 64'(div_ready), 64'd1);
        chk("arst_stamp8", 64'(stamp8), 64'd0);
        @(negedge clk);
        reset_n  = 1'b1;
        snap_req = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            chk("lit_tick_after_rst", 64'(tick), 64'(i == 4 || i == 8));
        end
        // Randomized traffic checked every cycle against the model
        for (int n = 0; n < 4000; n++) begin
            @(negedge clk);
            enable    = ($urandom_range(0, 9) != 0);
            div_valid = ($urandom_range(0, 7) == 0);
            div_value = 16'($urandom_range(0, 6));
            if ($urandom_range(0, 4) == 0) snap_req = !snap_req;
            if ($urandom_range(0, 499) == 0) begin
                #2 reset_n = 1'b0;
                #1 reset_n = 1'b1;
            end
        end
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
